dot_product_bram_engine: RTL and testbench
==========================================

# dot_product_bram_engine

Parametrised successor to the 4-core BRAM data mover. It streams `i_num_cnt` packed words from a node BRAM (b0) and a weight BRAM (b1) and runs `NUM_CORE` parallel lane-wise multiply-accumulates with selectable signed or unsigned arithmetic. At the end of a run it writes the per-core sums back to a result BRAM (b2) and also presents them on a packed output bus. It sits between the three true-dual-port BRAMs on their port A side; port B stays free for the host or testbench.

## Interface

- `CNT_BIT`, 31: width of the transfer count.
- `AWIDTH`, 12: BRAM address width.
- `MEM_SIZE`, 4096: BRAM depth in words.
- `IN_DATA_WIDTH`, 8: lane width.
- `NUM_CORE`, 4: number of lanes / accumulators.
- `DWIDTH`, 32: input word width. Must equal `NUM_CORE*IN_DATA_WIDTH`.
- `RWIDTH`, 32: accumulator and result width. Must be at least `2*IN_DATA_WIDTH`.

- `clk` in 1: single clock. One clock; reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous active-low reset.
- `i_run` in 1: start pulse, sampled only in IDLE.
- `i_num_cnt` in CNT_BIT: number of words to process.
- `i_signed` in 1: 1 selects two's-complement lanes, 0 selects unsigned lanes.
- `i_wb_base` in AWIDTH: b2 base address for the write-back.
- `o_idle`, `o_read`, `o_write`, `o_done` out 1: status flags.
- `addr_b0`/`addr_b1` out AWIDTH, `ce_b0`/`ce_b1` out 1, `we_b0`/`we_b1` out 1, `d_b0`/`d_b1` out DWIDTH, `q_b0`/`q_b1` in DWIDTH: read ports.
- `addr_b2` out AWIDTH, `ce_b2` out 1, `we_b2` out 1, `d_b2` out RWIDTH: result write port.
- `o_result` out NUM_CORE*RWIDTH: core k occupies bits `[(k+1)*RWIDTH-1 : k*RWIDTH]`.

## Operation

**States**
- IDLE → RUN when `i_run` is high.
- RUN → FLUSH after N read cycles.
- FLUSH → WRITE after 1 cycle.
- WRITE → DONE after NUM_CORE cycles.
- DONE → IDLE after 1 cycle.
- If N=0, IDLE goes directly to FLUSH on `i_run`.

**Run start**
- On `i_run` in IDLE, latch `i_num_cnt` (N), `i_signed`, and `i_wb_base`.
- Clear all accumulators on the same edge.
- `i_run` in any other state is ignored, and the latched values are not disturbed.

**RUN (reads)**
- On cycle j (0..N-1): `addr_b0 = addr_b1 = j mod 2^AWIDTH`, `ce_b0 = ce_b1 = 1`, `o_read = 1`.
- `we_b0`, `we_b1`, `d_b0`, `d_b1` are always 0.
- N > MEM_SIZE wraps the address; the count still completes N words.

**Accumulate**
- BRAM read latency is 1 cycle, so `q` for address j is valid on cycle j+1 (the last word arrives in FLUSH).
- Lane k of a word is bits `[DWIDTH-1-k*IN_DATA_WIDTH -: IN_DATA_WIDTH]`, so core 0 takes the most significant lane.
- Each valid cycle: `acc_k += lane_k(q_b0) * lane_k(q_b1)`.
- The product is signed or unsigned according to the latched mode, then sign- or zero-extended to RWIDTH.
- The sum wraps modulo 2^RWIDTH. No saturation.

**WRITE**
- On cycle k (0..NUM_CORE-1): `addr_b2 = (base+k) mod 2^AWIDTH`, `ce_b2 = we_b2 = 1`, `d_b2 = acc_k`, `o_write = 1`.

**DONE**
- `o_done = 1` for exactly 1 cycle.

**Status and result outputs**
- `o_idle = 1` in IDLE only.
- `o_result` is driven directly from the accumulators. It is stable from the first WRITE cycle until the next accepted `i_run`.

**Reset**
- Asynchronous, from any state, including mid-run.
- All registers return to zero and the state returns to IDLE.
- Reset values: `o_idle = 1`; every other output is 0, including all address, ce, we, d buses and `o_result`.
- An aborted run produces no b2 writes after reset asserts.

## Timing

- Take `i_run` sampled at edge 0.
- RUN occupies cycles 1..N.
- FLUSH is cycle N+1.
- WRITE occupies cycles N+2..N+1+NUM_CORE.
- DONE (`o_done` high) is cycle N+NUM_CORE+2.
- `o_idle` rises on cycle N+NUM_CORE+3.
- A new `i_run` is accepted on that cycle or later, so there are no back-to-back runs without one IDLE cycle.
- Throughput: one word per cycle per BRAM, with no bubbles inside RUN.

## Test plan

1. **Unsigned basic run.** Stimulus: N=4, `i_signed=0`, all b0 words = 0x01020304, all b1 words = 0x01010101, base=0x010. Required: results 4, 8, 12, 16; b2[0x010..0x013] = 4, 8, 12, 16; `o_done` on cycle 10 after `i_run`; `o_read` high for exactly 4 cycles.
2. **Signed vs unsigned on the same data.** Stimulus: N=3, b0 = 0xFFFFFFFF, b1 = 0x02020202. Required with `i_signed=1`: every result = 0xFFFFFFFA. Required with `i_signed=0`: every result = 1530.
3. **Zero count.** Stimulus: N=0. Required: no `o_read` cycles; 4 writes of 0; `o_done` on cycle 6.
4. **Write-back wrap.** Stimulus: base=0xFFE. Required: b2 writes land at 0xFFE, 0xFFF, 0x000, 0x001 in core order.
5. **Ignored start and mid-run reset.**
   - Part A stimulus: `i_run` pulsed mid-RUN. Required: no effect on the run.
   - Part B stimulus: `reset_n` low at cycle 3 of an N=8 run. Required: `o_idle=1`, all other outputs 0, and b2 untouched.
   - Part C stimulus: a following N=4 run. Required: it reproduces scenario 1 exactly.
6. **Full depth against golden reference.** Stimulus: N=4096, random node and weight files, `i_signed=0`. Required: `o_result` and b2 match the golden C reference output bit-exactly.

Source files
------------

// File: rtl/dot_product_bram_engine.sv
// Streams N packed words from node and weight BRAMs, runs NUM_CORE lane-wise
// multiply-accumulates, then writes the per-core sums to a result BRAM.
`default_nettype none

module dot_product_bram_engine #(
    parameter int CNT_BIT       = 31,
    parameter int AWIDTH        = 12,
    parameter int MEM_SIZE      = 4096,
    parameter int IN_DATA_WIDTH = 8,
    parameter int NUM_CORE      = 4,
    parameter int DWIDTH        = 32,
    parameter int RWIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_run,
    input  logic [CNT_BIT-1:0]           i_num_cnt,
    input  logic                         i_signed,
    input  logic [AWIDTH-1:0]            i_wb_base,
    output logic                         o_idle,
    output logic                         o_read,
    output logic                         o_write,
    output logic                         o_done,
    output logic [AWIDTH-1:0]            addr_b0,
    output logic                         ce_b0,
    output logic                         we_b0,
    output logic [DWIDTH-1:0]            d_b0,
    input  logic [DWIDTH-1:0]            q_b0,
    output logic [AWIDTH-1:0]            addr_b1,
    output logic                         ce_b1,
    output logic                         we_b1,
    output logic [DWIDTH-1:0]            d_b1,
    input  logic [DWIDTH-1:0]            q_b1,
    output logic [AWIDTH-1:0]            addr_b2,
    output logic                         ce_b2,
    output logic                         we_b2,
    output logic [RWIDTH-1:0]            d_b2,
    output logic [NUM_CORE*RWIDTH-1:0]   o_result
);

    localparam int IDW = IN_DATA_WIDTH;
    localparam int PW  = 2 * IDW + 2;
    localparam int WCW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

    if (DWIDTH != NUM_CORE * IDW || RWIDTH < 2 * IDW || MEM_SIZE > (1 << AWIDTH)) begin : g_bad_params
        $error("dot_product_bram_engine: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_BIT-1:0]           cnt_q, cnt_d;
    logic [CNT_BIT-1:0]           num_q, num_d;
    logic                         signed_q, signed_d;
    logic [AWIDTH-1:0]            base_q, base_d;
    logic [WCW-1:0]               wcnt_q, wcnt_d;
    logic                         vld_q;
    logic                         clr;
    logic [NUM_CORE*RWIDTH-1:0]   acc_q;
    logic [NUM_CORE*RWIDTH-1:0]   prod_ext;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        signed_d = signed_q;
        base_d   = base_q;
        wcnt_d   = wcnt_q;
        clr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    num_d    = i_num_cnt;
                    signed_d = i_signed;
                    base_d   = i_wb_base;
                    cnt_d    = '0;
                    clr      = 1'b1;
                    state_d  = (i_num_cnt == '0) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_BIT'(1);
                if (cnt_q == num_q - CNT_BIT'(1)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                wcnt_d  = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                wcnt_d = wcnt_q + WCW'(1);
                if (wcnt_q == WCW'(NUM_CORE - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            signed_q <= 1'b0;
            base_q   <= '0;
            wcnt_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            signed_q <= signed_d;
            base_q   <= base_d;
            wcnt_q   <= wcnt_d;
            vld_q    <= (state_q == S_RUN);
        end
    end

    // Lanes are widened by one bit so one signed multiplier covers both modes.
    for (genvar k = 0; k < NUM_CORE; k++) begin : g_core
        logic [IDW-1:0]      a_lane, b_lane;
        logic signed [IDW:0] a_ext, b_ext;
        logic signed [PW-1:0] prod;

        assign a_lane = q_b0[DWIDTH-1-k*IDW -: IDW];
        assign b_lane = q_b1[DWIDTH-1-k*IDW -: IDW];
        assign a_ext  = {signed_q & a_lane[IDW-1], a_lane};
        assign b_ext  = {signed_q & b_lane[IDW-1], b_lane};
        assign prod   = PW'(a_ext) * PW'(b_ext);

        if (RWIDTH > PW) begin : g_ext_wide
            assign prod_ext[k*RWIDTH +: RWIDTH] = {{(RWIDTH-PW){prod[PW-1]}}, prod};
        end else if (RWIDTH == PW) begin : g_ext_same
            assign prod_ext[k*RWIDTH +: RWIDTH] = prod;
        end else begin : g_ext_trunc
            assign prod_ext[k*RWIDTH +: RWIDTH] = prod[RWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (vld_q) begin
            for (int k = 0; k < NUM_CORE; k++) begin
                acc_q[k*RWIDTH +: RWIDTH] <= acc_q[k*RWIDTH +: RWIDTH] + prod_ext[k*RWIDTH +: RWIDTH];
            end
        end
    end

    always_comb begin
        d_b2 = '0;
        if (state_q == S_WRITE) begin
            for (int k = 0; k < NUM_CORE; k++) begin
                if (wcnt_q == WCW'(k)) begin
                    d_b2 = acc_q[k*RWIDTH +: RWIDTH];
                end
            end
        end
    end

    assign o_idle   = (state_q == S_IDLE);
    assign o_read   = (state_q == S_RUN);
    assign o_write  = (state_q == S_WRITE);
    assign o_done   = (state_q == S_DONE);

    assign addr_b0  = o_read ? cnt_q[AWIDTH-1:0] : '0;
    assign addr_b1  = addr_b0;
    assign ce_b0    = o_read;
    assign ce_b1    = o_read;
    assign we_b0    = 1'b0;
    assign we_b1    = 1'b0;
    assign d_b0     = '0;
    assign d_b1     = '0;

    assign addr_b2  = o_write ? base_q + AWIDTH'(wcnt_q) : '0;
    assign ce_b2    = o_write;
    assign we_b2    = o_write;
    assign o_result = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_product_bram_engine.sv
// Directed bench for dot_product_bram_engine with BRAM models and a b2 write scoreboard.
`default_nettype none

module tb_dot_product_bram_engine;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_run = 1'b0;
    logic [30:0]  i_num_cnt = '0;
    logic         i_signed = 1'b0;
    logic [11:0]  i_wb_base = '0;
    logic         o_idle, o_read, o_write, o_done;
    logic [11:0]  addr_b0, addr_b1, addr_b2;
    logic         ce_b0, ce_b1, ce_b2, we_b0, we_b1, we_b2;
    logic [31:0]  d_b0, d_b1, d_b2;
    logic [31:0]  q_b0 = '0, q_b1 = '0;
    logic [127:0] o_result;

    logic [31:0]  b0m [4096];
    logic [31:0]  b1m [4096];
    logic [31:0]  b2m [4096];

    int           checks = 0;
    int           failures = 0;
    logic [43:0]  exp_q [$];

    always #5 clk = ~clk;

    dot_product_bram_engine dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_signed(i_signed), .i_wb_base(i_wb_base),
        .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
        .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .d_b0(d_b0), .q_b0(q_b0),
        .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .d_b1(d_b1), .q_b1(q_b1),
        .addr_b2(addr_b2), .ce_b2(ce_b2), .we_b2(we_b2), .d_b2(d_b2),
        .o_result(o_result)
    );

    always @(posedge clk) begin
        if (ce_b0) q_b0 <= b0m[addr_b0];
        if (ce_b1) q_b1 <= b1m[addr_b1];
        if (ce_b2 && we_b2) b2m[addr_b2] <= d_b2;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every b2 write must match the head of the scoreboard, in order.
    always @(negedge clk) begin
        if (ce_b2 === 1'b1 && we_b2 === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("b2_unexpected_write", {84'd0, addr_b2, d_b2}, 128'd0);
            end else begin
                chk("b2_write", {84'd0, addr_b2, d_b2}, {84'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [127:0] golden(input int n, input bit sg);
        logic [31:0] acc [4];
        logic [31:0] w0, w1;
        logic [7:0]  a, b;
        int          pa, pb;
        for (int k = 0; k < 4; k++) acc[k] = '0;
        for (int j = 0; j < n; j++) begin
            w0 = b0m[j % 4096];
            w1 = b1m[j % 4096];
            for (int k = 0; k < 4; k++) begin
                a  = w0[31-8*k -: 8];
                b  = w1[31-8*k -: 8];
                pa = sg ? int'($signed(a)) : int'(a);
                pb = sg ? int'($signed(b)) : int'(b);
                acc[k] = acc[k] + 32'(pa * pb);
            end
        end
        return {acc[3], acc[2], acc[1], acc[0]};
    endfunction

    task automatic fill(input logic [31:0] p0, input logic [31:0] p1);
        for (int i = 0; i < 4096; i++) begin
            b0m[i] = p0;
            b1m[i] = p1;
        end
    endtask

    task automatic do_run(input int n, input bit sg, input logic [11:0] base, input bit poke);
        logic [127:0] exp_res;
        int rd, wr, bad, done_c;
        exp_res = golden(n, sg);
        for (int k = 0; k < 4; k++) exp_q.push_back({base + 12'(k), exp_res[k*32 +: 32]});
        rd = 0; wr = 0; bad = 0; done_c = -1;
        @(negedge clk);
        i_run = 1'b1; i_num_cnt = 31'(n); i_signed = sg; i_wb_base = base;
        @(posedge clk);
        #1;
        i_run = 1'b0; i_num_cnt = 31'($urandom); i_signed = ~sg; i_wb_base = 12'($urandom);
        for (int c = 1; c <= n + 20; c++) begin
            @(negedge clk);
            if (poke) i_run = (c == 2);
            if (o_read) begin
                rd++;
                if (addr_b0 !== 12'((c - 1) % 4096) || addr_b1 !== addr_b0 || !ce_b0 || !ce_b1) bad++;
            end
            if (we_b0 !== 1'b0 || we_b1 !== 1'b0 || d_b0 !== '0 || d_b1 !== '0) bad++;
            if (o_write) wr++;
            if (o_done) begin
                done_c = c;
                break;
            end
        end
        i_run = 1'b0;
        chk("done_cycle", 128'(done_c), 128'(n + 6));
        chk("read_cycles", 128'(rd), 128'(n));
        chk("write_cycles", 128'(wr), 128'd4);
        chk("read_port_behaviour", 128'(bad), 128'd0);
        chk("result_at_done", o_result, exp_res);
        @(negedge clk);
        chk("idle_after_done", {127'd0, o_idle}, 128'd1);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #12;
        chk("reset_idle", {127'd0, o_idle}, 128'd1);
        chk("reset_outputs", {o_read, o_write, o_done, ce_b0, ce_b1, ce_b2, we_b2, addr_b0, addr_b2, d_b2},
            128'd0);
        chk("reset_result", o_result, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: unsigned basic
        fill(32'h01020304, 32'h01010101);
        do_run(4, 1'b0, 12'h010, 1'b0);
        chk("s1_result", o_result, {32'd16, 32'd12, 32'd8, 32'd4});
        chk("s1_b2", {b2m[12'h010], b2m[12'h011], b2m[12'h012], b2m[12'h013]},
            {32'd4, 32'd8, 32'd12, 32'd16});

        // 2: signed vs unsigned on the same data
        fill(32'hFFFFFFFF, 32'h02020202);
        do_run(3, 1'b1, 12'h020, 1'b0);
        chk("s2_signed", o_result, {4{32'hFFFFFFFA}});
        do_run(3, 1'b0, 12'h020, 1'b0);
        chk("s2_unsigned", o_result, {4{32'd1530}});

        // 3: zero count
        do_run(0, 1'b0, 12'h030, 1'b0);
        chk("s3_result", o_result, 128'd0);

        // 4: write-back address wrap
        fill(32'h05060708, 32'h01020304);
        do_run(5, 1'b0, 12'hFFE, 1'b0);
        chk("s4_b2_wrap", {b2m[12'hFFE], b2m[12'hFFF], b2m[12'h000], b2m[12'h001]},
            {32'd25, 32'd60, 32'd105, 32'd160});

        // 5A: start pulse mid-run is ignored
        fill(32'h01020304, 32'h01010101);
        do_run(4, 1'b0, 12'h010, 1'b1);
        chk("s5a_result", o_result, {32'd16, 32'd12, 32'd8, 32'd4});

        // 5B: reset during cycle 3 of an N=8 run
        @(negedge clk);
        i_run = 1'b1; i_num_cnt = 31'd8; i_signed = 1'b0; i_wb_base = 12'h040;
        @(posedge clk);
        #1 i_run = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("s5b_idle", {127'd0, o_idle}, 128'd1);
        chk("s5b_outputs", {o_read, o_write, o_done, ce_b0, ce_b1, ce_b2, we_b2, addr_b0, addr_b1, addr_b2, d_b2},
            128'd0);
        chk("s5b_result", o_result, 128'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("s5b_still_idle", {127'd0, o_idle}, 128'd1);

        // 5C: clean rerun reproduces scenario 1
        do_run(4, 1'b0, 12'h010, 1'b0);
        chk("s5c_result", o_result, {32'd16, 32'd12, 32'd8, 32'd4});

        // 6: full depth, random data
        for (int i = 0; i < 4096; i++) begin
            b0m[i] = $urandom;
            b1m[i] = $urandom;
        end
        do_run(4096, 1'b0, 12'h100, 1'b0);
        chk("s6_b2", {b2m[12'h103], b2m[12'h102], b2m[12'h101], b2m[12'h100]}, golden(4096, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
